// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl : multicycle MIPS control FSM with memory wait/timeout
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mips_multicycle_ctrl #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             wb_sel_0,
    output logic             wb_sel_1,
    output logic [2:0]       state_o,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam int WCNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXEC    = 3'd2,
        S_MEM_ACC = 3'd3,
        S_WB      = 3'd4,
        S_BRANCH  = 3'd5,
        S_JUMP    = 3'd6
    } state_t;

    state_t            state;
    state_t            nxt_state;
    logic [5:0]        op_q;
    logic [5:0]        nxt_op;
    logic [WCNT_W-1:0] wait_cnt;
    logic              active;
    logic              fetch_q;
    logic              jump_pcw;
    logic              timeout;
    logic              retire;
    logic              waiting;

    // Registered outputs lag one cycle behind reset, so FETCH idles once
    // (active=0) before its strobes appear and before it may advance.
    always_comb begin
        nxt_state = state;
        nxt_op    = op_q;
        timeout   = 1'b0;
        retire    = 1'b0;
        waiting   = 1'b0;
        case (state)
            S_FETCH: begin
                if (active) begin
                    if (mem_ready) begin
                        nxt_state = S_DECODE;
                    end else begin
                        waiting = 1'b1;
                        timeout = (wait_cnt == WCNT_LAST);
                    end
                end
            end
            S_DECODE: begin
                nxt_op = opcode;
                case (opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_ADDI: nxt_state = S_EXEC;
                    OP_BEQ:                          nxt_state = S_BRANCH;
                    OP_J, OP_JAL:                    nxt_state = S_JUMP;
                    default:                         nxt_state = S_FETCH;
                endcase
            end
            S_EXEC: begin
                nxt_state = (op_q == OP_LW || op_q == OP_SW) ? S_MEM_ACC : S_WB;
            end
            S_MEM_ACC: begin
                if (mem_ready) begin
                    if (op_q == OP_LW) begin
                        nxt_state = S_WB;
                    end else begin
                        nxt_state = S_FETCH;
                        retire    = 1'b1;
                    end
                end else begin
                    waiting = 1'b1;
                    if (wait_cnt == WCNT_LAST) begin
                        timeout   = 1'b1;
                        nxt_state = S_FETCH;
                    end
                end
            end
            S_WB, S_BRANCH, S_JUMP: begin
                nxt_state = S_FETCH;
                retire    = 1'b1;
            end
            default: nxt_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_FETCH;
            op_q          <= 6'd0;
            wait_cnt      <= '0;
            active        <= 1'b0;
            instr_count   <= '0;
            mem_timeout   <= 1'b0;
            fetch_q       <= 1'b0;
            jump_pcw      <= 1'b0;
            pc_write_cond <= 1'b0;
            pc_src        <= 2'b00;
            iord          <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            reg_write     <= 1'b0;
            reg_dst       <= 2'b00;
            alu_src_a     <= 1'b0;
            alu_src_b     <= 2'b00;
            alu_op        <= 2'b00;
            wb_sel_0      <= 1'b0;
            wb_sel_1      <= 1'b0;
        end else begin
            state       <= nxt_state;
            op_q        <= nxt_op;
            active      <= 1'b1;
            mem_timeout <= timeout;
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
            if (nxt_state != state || timeout) begin
                wait_cnt <= '0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + WCNT_W'(1);
            end

            // Outputs for the cycle about to begin, decoded from the next state.
            fetch_q       <= 1'b0;
            jump_pcw      <= 1'b0;
            pc_write_cond <= 1'b0;
            pc_src        <= 2'b00;
            iord          <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            reg_write     <= 1'b0;
            reg_dst       <= 2'b00;
            alu_src_a     <= 1'b0;
            alu_src_b     <= 2'b00;
            alu_op        <= 2'b00;
            wb_sel_0      <= 1'b0;
            wb_sel_1      <= 1'b0;
            case (nxt_state)
                S_FETCH: begin
                    fetch_q   <= 1'b1;
                    mem_read  <= 1'b1;
                    alu_src_b <= 2'b01;
                end
                S_DECODE: begin
                    alu_src_b <= 2'b11;
                end
                S_EXEC: begin
                    alu_src_a <= 1'b1;
                    if (nxt_op == OP_RTYPE) begin
                        alu_op <= 2'b10;
                    end else begin
                        alu_src_b <= 2'b10;
                    end
                end
                S_MEM_ACC: begin
                    iord      <= 1'b1;
                    mem_read  <= (nxt_op == OP_LW);
                    mem_write <= (nxt_op == OP_SW);
                end
                S_WB: begin
                    reg_write <= 1'b1;
                    if (nxt_op == OP_RTYPE) begin
                        reg_dst <= 2'b01;
                    end
                    if (nxt_op == OP_LW) begin
                        wb_sel_0 <= 1'b1;
                    end
                end
                S_BRANCH: begin
                    alu_src_a     <= 1'b1;
                    alu_op        <= 2'b01;
                    pc_write_cond <= 1'b1;
                    pc_src        <= 2'b01;
                end
                S_JUMP: begin
                    jump_pcw <= 1'b1;
                    pc_src   <= 2'b10;
                    if (nxt_op == OP_JAL) begin
                        reg_write <= 1'b1;
                        reg_dst   <= 2'b10;
                        wb_sel_1  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // IR load and PC+4 update follow mem_ready combinationally during FETCH.
    assign ir_write = fetch_q & mem_ready;
    assign pc_write = (fetch_q & mem_ready) | jump_pcw;
    assign state_o  = state;

    // The zero flag only matters to the datapath's PC-load gating.
    logic unused_zero;
    assign unused_zero = zero;

endmodule

`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle MIPS control FSM that sequences the shared datapath: PC, IR, memory port, ALU and register file.
- Drives the register-file writeback source selects (wb_sel_0/wb_sel_1), which choose ALU result, memory data or PC+4 (for JAL).
- Handles memory wait states with a ready handshake and a timeout counter.
- Counts retired instructions.

Parameters:
- TIMEOUT_CYC, 16, maximum cycles a memory access may wait for mem_ready before abort.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- opcode  in  6  IR[31:26]; valid from the DECODE cycle onward.
- zero  in  1  ALU zero flag, used in BRANCH.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero=1 (beq).
- pc_src  out  2  00 = ALU (PC+4), 01 = ALUOut (branch target), 10 = jump target.
- iord  out  1  memory address source: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load.
- reg_write  out  1  register-file write enable.
- reg_dst  out  2  00 = rt, 01 = rd, 10 = $31.
- alu_src_a  out  1  0 = PC, 1 = rs.
- alu_src_b  out  2  00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- wb_sel_0  out  1  writeback select bit 0.
- wb_sel_1  out  1  writeback select bit 1.
- state_o  out  3  current state encoding, for debug.
- mem_timeout  out  1  one-cycle pulse when a memory access is aborted.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state = FETCH, op_q = 0, wait counter = 0, instr_count = 0.
  - All outputs are 0 during and after reset until FETCH asserts its strobes.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM_ACC=3, WB=4, BRANCH=5, JUMP=6. Code 7 is unreachable; if entered, go to FETCH.
- Writeback select encoding {wb_sel_1, wb_sel_0}:
  - 00 = ALU result, 01 = memory data, 10 = PC+4.
  - 11 is never driven.
  - Both bits are 0 whenever reg_write=0.
- FETCH:
  - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_write equal mem_ready (Mealy).
  - On mem_ready=1, go to DECODE.
- DECODE:
  - Captures opcode into op_q.
  - Drives alu_src_a=0, alu_src_b=11, alu_op=00 (precompute branch target).
  - Next state by opcode:
    - R-type 000000, lw 100011, sw 101011, addi 001000 -> EXEC.
    - beq 000100 -> BRANCH.
    - j 000010, jal 000011 -> JUMP.
    - Any other opcode -> FETCH; instruction is not counted.
- EXEC:
  - Drives alu_src_a=1.
  - R-type: alu_src_b=00, alu_op=10. All others: alu_src_b=10, alu_op=00.
  - Next state: lw/sw -> MEM_ACC; R-type/addi -> WB.
- MEM_ACC:
  - Drives iord=1; mem_read=1 for lw, mem_write=1 for sw. Strobes are held until mem_ready.
  - On mem_ready=1: lw -> WB; sw -> FETCH and retire.
  - Wait counter increments each cycle mem_ready=0.
  - When the count reaches TIMEOUT_CYC-1 with mem_ready still 0, the next edge goes to FETCH, pulses mem_timeout for one cycle and does not retire.
  - The same timeout rule applies to FETCH waits.
  - The counter clears on every state change.
- WB:
  - Drives reg_write=1 and goes to FETCH, retiring the instruction.
  - R-type: reg_dst=01, wb=00. addi: reg_dst=00, wb=00. lw: reg_dst=00, wb=01.
- BRANCH: drives alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01; go to FETCH and retire.
- JUMP:
  - Drives pc_write=1, pc_src=10; go to FETCH and retire.
  - jal additionally drives reg_write=1, reg_dst=10, wb=10 in the same cycle.
- Retire: instr_count increments by 1 on the edge leaving the final state. Wraps modulo 2^CNT_W.
- Latency with zero memory wait states:
  - R-type/addi/lw: 4/4/5 cycles.
  - sw: 4 cycles.
  - beq/j/jal: 3 cycles.
- mem_ready outside FETCH/MEM_ACC is ignored.
- Reset asserted mid-instruction aborts it: no retire, no strobes on the next cycle.

Test Plan:
- Reset, then R-type (opcode 0) with mem_ready tied 1 -> states 0,1,2,4,0; reg_write=1 with reg_dst=01, wb=00 in cycle 4; instr_count=1.
- lw with mem_ready low for 3 cycles in MEM_ACC -> MEM_ACC held 4 cycles with mem_read=1, iord=1; WB has wb_sel_0=1, wb_sel_1=0; count +1.
- jal -> states 0,1,6; JUMP cycle has pc_write=1, pc_src=10, reg_write=1, reg_dst=10, wb_sel_1=1, wb_sel_0=0; never both sel bits high over a 1000-instruction random run.
- sw with mem_ready never asserted, TIMEOUT_CYC=16 -> exactly 16 cycles in MEM_ACC, mem_timeout pulses once, returns to FETCH, instr_count unchanged.
- beq with zero=1 then zero=0 -> pc_write_cond=1, pc_src=01 in BRANCH both times; 3-cycle latency; count +2.
- Illegal opcode 111111 and reset asserted in EXEC -> illegal: FETCH after DECODE with no count; reset: state_o=0, all strobes 0, instr_count=0 next cycle.
